// File: rtl/sram_sched_pkg.sv
// ============================================================================
// Module   : sram_sched_pkg
// Purpose  : Shared constants, field layout and helpers for the SRAM port
//            scheduler (requester indices, word/address/mask widths, the
//            writer request bit layout and the round-robin pick function).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_sched_pkg;

    // Field widths of the SRAM command interface
    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 32;
    localparam int MASK_W   = 4;
    localparam int W_DIN_W  = MASK_W + ADDR_W + DATA_W;   // 54

    // Bit offsets inside a writer request word {mask, addr, data}
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = DATA_LSB + DATA_W;          // 32
    localparam int MASK_LSB = ADDR_LSB + ADDR_W;          // 50

    // Requester indices used by the round-robin arbiter
    localparam int         NUM_REQ = 4;
    localparam logic [1:0] REQ_W0  = 2'd0;
    localparam logic [1:0] REQ_W1  = 2'd1;
    localparam logic [1:0] REQ_R0  = 2'd2;
    localparam logic [1:0] REQ_R1  = 2'd3;

    // Writer request as it arrives on wN_din
    typedef struct packed {
        logic [MASK_W-1:0] mask;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // First eligible requester searching upward (mod 4) from ptr.
    // Returns ptr when nothing is eligible; callers qualify with |elig.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                           input logic [1:0]         ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with registered storage and a combinational
//            head. Push and pop may happen in the same cycle. A push while
//            full and a pop while empty are ignored.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            push, push_data - write side
//            pop, pop_data   - read side (pop_data is the current head)
//            full, empty     - occupancy flags
// Params   : WIDTH - word width; DEPTH - entries (power of 2, >= 2)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;   // extra wrap bit distinguishes full from empty

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             w_push_en;
    logic             w_pop_en;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_push_en = push && !full;
    assign w_pop_en  = pop && !empty;
    assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(w_push_en);
        rd_ptr_d = rd_ptr_q + PW'(w_pop_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_port_scheduler.sv
// ============================================================================
// Module   : sram_port_scheduler
// Purpose  : Shares one SRAM command port between two writers and two
//            readers using round-robin arbitration (w0, w1, r0, r1). Read
//            returns arrive in order and are steered to per-reader return
//            FIFOs using a tag FIFO of reader ids. Per-reader credits keep
//            the return FIFOs from overflowing.
// Ports    : clock, reset                 - clock, sync active-high reset
//            wN_din_valid/wN_din/ready    - writer N {mask,addr,data}
//            rN_din_valid/rN_din/ready    - reader N address
//            rN_dout_valid/rN_dout/ready  - reader N return data
//            sram_addr_valid/sram_ready   - SRAM command handshake
//            sram_addr/data_in/write_mask - SRAM command (mask 0 = read)
//            sram_data_out(_valid)        - in-order read returns
//            err_orphan                   - sticky: return with no read
// Params   : RD_FIFO_DEPTH - per-reader return FIFO depth (power of 2)
//            TAG_DEPTH     - max in-flight reads (power of 2)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_scheduler
    import sram_sched_pkg::*;
#(
    parameter int RD_FIFO_DEPTH = 4,
    parameter int TAG_DEPTH     = 8
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               w0_din_valid,
    input  logic [W_DIN_W-1:0] w0_din,
    output logic               w0_din_ready,
    input  logic               w1_din_valid,
    input  logic [W_DIN_W-1:0] w1_din,
    output logic               w1_din_ready,

    input  logic               r0_din_valid,
    input  logic [ADDR_W-1:0]  r0_din,
    output logic               r0_din_ready,
    input  logic               r1_din_valid,
    input  logic [ADDR_W-1:0]  r1_din,
    output logic               r1_din_ready,

    output logic               r0_dout_valid,
    output logic [DATA_W-1:0]  r0_dout,
    input  logic               r0_dout_ready,
    output logic               r1_dout_valid,
    output logic [DATA_W-1:0]  r1_dout,
    input  logic               r1_dout_ready,

    output logic               sram_addr_valid,
    input  logic               sram_ready,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [DATA_W-1:0]  sram_data_in,
    output logic [MASK_W-1:0]  sram_write_mask,
    input  logic [DATA_W-1:0]  sram_data_out,
    input  logic               sram_data_out_valid,

    output logic               err_orphan
);

    // Credit counts 0..RD_FIFO_DEPTH inclusive
    localparam int CRED_W = $clog2(RD_FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]                   ptr_q, ptr_d;
    logic [1:0][CRED_W-1:0]       credit_q, credit_d;
    logic                         err_orphan_q, err_orphan_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    wr_req_t              w_wr0;
    wr_req_t              w_wr1;
    logic                 w_drop0;
    logic                 w_drop1;
    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_any;
    logic [1:0]           w_grant;
    logic                 w_xfer;
    logic [1:0]           w_issue;     // read issued for reader n this cycle
    logic [1:0]           w_deq;       // word consumed by reader n this cycle

    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic                 w_tag_head;
    logic                 w_tag_pop;
    logic                 w_ret0_push;
    logic                 w_ret1_push;
    logic                 w_ret0_empty;
    logic                 w_ret1_empty;
    logic                 w_ret0_full_unused;
    logic                 w_ret1_full_unused;

    assign w_wr0 = w0_din;
    assign w_wr1 = w1_din;

    // Zero-mask writes carry nothing; swallow them without arbitration.
    assign w_drop0 = w0_din_valid && (w_wr0.mask == '0);
    assign w_drop1 = w1_din_valid && (w_wr1.mask == '0);

    always_comb begin
        w_elig         = '0;
        w_elig[REQ_W0] = w0_din_valid && (w_wr0.mask != '0);
        w_elig[REQ_W1] = w1_din_valid && (w_wr1.mask != '0);
        w_elig[REQ_R0] = r0_din_valid && (credit_q[0] < CRED_W'(RD_FIFO_DEPTH))
                         && !w_tag_full;
        w_elig[REQ_R1] = r1_din_valid && (credit_q[1] < CRED_W'(RD_FIFO_DEPTH))
                         && !w_tag_full;
    end

    assign w_any   = |w_elig;
    assign w_grant = rr_pick(w_elig, ptr_q);
    assign w_xfer  = w_any && sram_ready;

    // ------------------------------------------------------------------
    // SRAM command mux
    // ------------------------------------------------------------------
    assign sram_addr_valid = w_any;

    always_comb begin
        sram_addr       = '0;
        sram_data_in    = '0;
        sram_write_mask = '0;
        if (w_any) begin
            case (w_grant)
                REQ_W0: begin
                    sram_addr       = w_wr0.addr;
                    sram_data_in    = w_wr0.data;
                    sram_write_mask = w_wr0.mask;
                end
                REQ_W1: begin
                    sram_addr       = w_wr1.addr;
                    sram_data_in    = w_wr1.data;
                    sram_write_mask = w_wr1.mask;
                end
                REQ_R0:  sram_addr = r0_din;
                default: sram_addr = r1_din;
            endcase
        end
    end

    // Only the grantee sees sram_ready; a dropped write is accepted alone.
    assign w0_din_ready = w_drop0 || (w_any && (w_grant == REQ_W0) && sram_ready);
    assign w1_din_ready = w_drop1 || (w_any && (w_grant == REQ_W1) && sram_ready);
    assign r0_din_ready = w_any && (w_grant == REQ_R0) && sram_ready;
    assign r1_din_ready = w_any && (w_grant == REQ_R1) && sram_ready;

    // ------------------------------------------------------------------
    // Pointer, credits, orphan flag
    // ------------------------------------------------------------------
    assign w_issue[0] = w_xfer && (w_grant == REQ_R0);
    assign w_issue[1] = w_xfer && (w_grant == REQ_R1);
    assign w_deq[0]   = r0_dout_valid && r0_dout_ready;
    assign w_deq[1]   = r1_dout_valid && r1_dout_ready;

    always_comb begin
        ptr_d = w_xfer ? (w_grant + 2'd1) : ptr_q;
    end

    // A return moves a word from "in flight" to "in FIFO", so it leaves
    // the credit alone; only issue and consumption change it.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            credit_d[n] = credit_q[n];
            if (w_issue[n] && !w_deq[n]) begin
                credit_d[n] = credit_q[n] + CRED_W'(1);
            end else if (!w_issue[n] && w_deq[n]) begin
                credit_d[n] = credit_q[n] - CRED_W'(1);
            end
        end
    end

    always_comb begin
        err_orphan_d = err_orphan_q || (sram_data_out_valid && w_tag_empty);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q        <= '0;
            credit_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            credit_q     <= credit_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign err_orphan = err_orphan_q;

    // ------------------------------------------------------------------
    // Tag FIFO: reader id of every outstanding read, in issue order
    // ------------------------------------------------------------------
    assign w_tag_pop = sram_data_out_valid && !w_tag_empty;

    sync_fifo #(
        .WIDTH (1),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clock),
        .rst       (reset),
        .push      (w_issue[0] || w_issue[1]),
        .push_data (w_issue[1]),
        .pop       (w_tag_pop),
        .pop_data  (w_tag_head),
        .full      (w_tag_full),
        .empty     (w_tag_empty)
    );

    // ------------------------------------------------------------------
    // Return FIFOs: returns land here and are visible the next cycle
    // ------------------------------------------------------------------
    assign w_ret0_push = w_tag_pop && !w_tag_head;
    assign w_ret1_push = w_tag_pop &&  w_tag_head;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_ret0_fifo (
        .clk       (clock),
        .rst       (reset),
        .push      (w_ret0_push),
        .push_data (sram_data_out),
        .pop       (w_deq[0]),
        .pop_data  (r0_dout),
        .full      (w_ret0_full_unused),
        .empty     (w_ret0_empty)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_ret1_fifo (
        .clk       (clock),
        .rst       (reset),
        .push      (w_ret1_push),
        .push_data (sram_data_out),
        .pop       (w_deq[1]),
        .pop_data  (r1_dout),
        .full      (w_ret1_full_unused),
        .empty     (w_ret1_empty)
    );

    assign r0_dout_valid = !w_ret0_empty;
    assign r1_dout_valid = !w_ret1_empty;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_scheduler.sv
// ============================================================================
// Module   : tb_sram_port_scheduler
// Purpose  : Self-checking bench for sram_port_scheduler. A queue-based
//            reference model predicts every output each cycle; directed
//            scenarios add constant expectations, then a randomized phase
//            exercises arbitration, credits and return steering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_scheduler;

    localparam int RD_FIFO_DEPTH = 4;
    localparam int TAG_DEPTH     = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        w0_din_valid, w1_din_valid;
    logic [53:0] w0_din, w1_din;
    logic        w0_din_ready, w1_din_ready;
    logic        r0_din_valid, r1_din_valid;
    logic [17:0] r0_din, r1_din;
    logic        r0_din_ready, r1_din_ready;
    logic        r0_dout_valid, r1_dout_valid;
    logic [31:0] r0_dout, r1_dout;
    logic        r0_dout_ready, r1_dout_ready;
    logic        sram_addr_valid, sram_ready;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;
    logic        err_orphan;

    always #5 clock = ~clock;

    sram_port_scheduler #(
        .RD_FIFO_DEPTH (RD_FIFO_DEPTH),
        .TAG_DEPTH     (TAG_DEPTH)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .w0_din_valid        (w0_din_valid),
        .w0_din              (w0_din),
        .w0_din_ready        (w0_din_ready),
        .w1_din_valid        (w1_din_valid),
        .w1_din              (w1_din),
        .w1_din_ready        (w1_din_ready),
        .r0_din_valid        (r0_din_valid),
        .r0_din              (r0_din),
        .r0_din_ready        (r0_din_ready),
        .r1_din_valid        (r1_din_valid),
        .r1_din              (r1_din),
        .r1_din_ready        (r1_din_ready),
        .r0_dout_valid       (r0_dout_valid),
        .r0_dout             (r0_dout),
        .r0_dout_ready       (r0_dout_ready),
        .r1_dout_valid       (r1_dout_valid),
        .r1_dout             (r1_dout),
        .r1_dout_ready       (r1_dout_ready),
        .sram_addr_valid     (sram_addr_valid),
        .sram_ready          (sram_ready),
        .sram_addr           (sram_addr),
        .sram_data_in        (sram_data_in),
        .sram_write_mask     (sram_write_mask),
        .sram_data_out       (sram_data_out),
        .sram_data_out_valid (sram_data_out_valid),
        .err_orphan          (err_orphan)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_ptr;
    int          m_credit [2];
    bit          m_tags [$];
    logic [31:0] m_ret0 [$];
    logic [31:0] m_ret1 [$];
    bit          m_orphan;
    bit          m_any;
    int          m_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        w0_din_valid = 0; w0_din = '0; w1_din_valid = 0; w1_din = '0;
        r0_din_valid = 0; r0_din = '0; r1_din_valid = 0; r1_din = '0;
        r0_dout_ready = 0; r1_dout_ready = 0; sram_ready = 0;
        sram_data_out = '0; sram_data_out_valid = 0;
    endtask

    // Predict and compare every output for the current inputs.
    task automatic model_check();
        bit [3:0]    e;
        bit [3:0]    er;
        bit          d0, d1;
        logic [17:0] ea;
        logic [31:0] ed;
        logic [3:0]  em;
        e[0] = w0_din_valid && (w0_din[53:50] != 4'd0);
        e[1] = w1_din_valid && (w1_din[53:50] != 4'd0);
        e[2] = r0_din_valid && (m_credit[0] < RD_FIFO_DEPTH) && (m_tags.size() < TAG_DEPTH);
        e[3] = r1_din_valid && (m_credit[1] < RD_FIFO_DEPTH) && (m_tags.size() < TAG_DEPTH);
        m_any   = (e != 4'd0);
        m_grant = 0;
        for (int i = 3; i >= 0; i--) begin
            if (e[(m_ptr + i) % 4]) m_grant = (m_ptr + i) % 4;
        end
        d0 = w0_din_valid && (w0_din[53:50] == 4'd0);
        d1 = w1_din_valid && (w1_din[53:50] == 4'd0);
        ea = '0; ed = '0; em = '0;
        if (m_any) begin
            case (m_grant)
                0:       {em, ea, ed} = w0_din;
                1:       {em, ea, ed} = w1_din;
                2:       ea = r0_din;
                default: ea = r1_din;
            endcase
        end
        er[0] = d0 || (m_any && m_grant == 0 && sram_ready);
        er[1] = d1 || (m_any && m_grant == 1 && sram_ready);
        er[2] = m_any && m_grant == 2 && sram_ready;
        er[3] = m_any && m_grant == 3 && sram_ready;
        check("addr_valid", 32'(sram_addr_valid), 32'(m_any));
        check("sram_addr", 32'(sram_addr), 32'(ea));
        check("sram_data_in", sram_data_in, ed);
        check("sram_mask", 32'(sram_write_mask), 32'(em));
        check("din_ready", 32'({r1_din_ready, r0_din_ready, w1_din_ready, w0_din_ready}), 32'(er));
        check("r0_dout_valid", 32'(r0_dout_valid), 32'(m_ret0.size() > 0));
        if (m_ret0.size() > 0) check("r0_dout", r0_dout, m_ret0[0]);
        check("r1_dout_valid", 32'(r1_dout_valid), 32'(m_ret1.size() > 0));
        if (m_ret1.size() > 0) check("r1_dout", r1_dout, m_ret1[0]);
        check("err_orphan", 32'(err_orphan), 32'(m_orphan));
    endtask

    // Advance the model across a rising edge using the inputs just applied.
    task automatic model_update();
        bit t;
        if (reset) begin
            m_ptr = 0; m_credit[0] = 0; m_credit[1] = 0;
            m_tags.delete(); m_ret0.delete(); m_ret1.delete();
            m_orphan = 0;
            return;
        end
        if (m_ret0.size() > 0 && r0_dout_ready) begin void'(m_ret0.pop_front()); m_credit[0]--; end
        if (m_ret1.size() > 0 && r1_dout_ready) begin void'(m_ret1.pop_front()); m_credit[1]--; end
        if (sram_data_out_valid) begin
            if (m_tags.size() > 0) begin
                t = m_tags.pop_front();
                if (t) m_ret1.push_back(sram_data_out);
                else   m_ret0.push_back(sram_data_out);
            end else begin
                m_orphan = 1;
            end
        end
        if (m_any && sram_ready) begin
            if (m_grant >= 2) begin
                m_tags.push_back(m_grant == 3);
                m_credit[m_grant - 2]++;
            end
            m_ptr = (m_grant + 1) % 4;
        end
    endtask

    // Inputs are applied at the falling edge; outputs are checked 1 ns later.
    task automatic step();
        #1;
        model_check();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic drain();
        clear_inputs();
        r0_dout_ready = 1; r1_dout_ready = 1;
        for (int k = 0; k < 40; k++) begin
            sram_data_out_valid = (m_tags.size() > 0);
            sram_data_out       = $urandom;
            step();
        end
        sram_data_out_valid = 0;
        #1;
        check("drain_empty", 32'({r1_dout_valid, r0_dout_valid}), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] rr_exp [4];
        int          n_issued;
        rr_exp = '{18'h100, 18'h101, 18'h200, 18'h201};

        clear_inputs();
        reset = 1;
        m_ptr = 0; m_credit[0] = 0; m_credit[1] = 0; m_orphan = 0;
        @(negedge clock);
        step();
        step();
        reset = 0;
        #1;
        check("post_reset_ctrl", 32'({sram_addr_valid, w0_din_ready, w1_din_ready, r0_din_ready,
                                      r1_din_ready, r0_dout_valid, r1_dout_valid, err_orphan}), 32'd0);
        check("post_reset_bus", 32'(sram_addr) | sram_data_in | 32'(sram_write_mask), 32'd0);
        step();

        // Round-robin over all four requesters
        w0_din_valid = 1; w0_din = {4'hF, 18'h100, 32'h1111_0000};
        w1_din_valid = 1; w1_din = {4'h3, 18'h101, 32'h2222_0000};
        r0_din_valid = 1; r0_din = 18'h200;
        r1_din_valid = 1; r1_din = 18'h201;
        sram_ready = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_order", 32'(sram_addr), 32'(rr_exp[k % 4]));
            step();
        end
        drain();

        // Zero-mask write is dropped
        clear_inputs();
        sram_ready = 1; w0_din_valid = 1; w0_din = {4'h0, 18'd5, 32'hDEAD_BEEF};
        #1;
        check("drop_ready", 32'(w0_din_ready), 32'd1);
        check("drop_no_cmd", 32'(sram_addr_valid), 32'd0);
        step();

        // Credit limit: only RD_FIFO_DEPTH reads while nothing is consumed
        clear_inputs();
        sram_ready = 1; r0_din_valid = 1; n_issued = 0;
        for (int k = 0; k < 6; k++) begin
            r0_din = 18'h300 + 18'(n_issued);
            #1;
            if (r0_din_ready) n_issued++;
            step();
        end
        check("r0_credit_cap", 32'(n_issued), 32'd4);
        for (int k = 0; k < 4; k++) begin
            sram_data_out_valid = 1; sram_data_out = 32'hC0 + 32'(k);
            #1;
            check("r0_blocked", 32'(r0_din_ready), 32'd0);
            step();
        end
        sram_data_out_valid = 0;
        r0_dout_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("r0_order", r0_dout, 32'hC0 + 32'(k));
            if (k == 0) check("r0_still_full", 32'(r0_din_ready), 32'd0);
            if (k == 1) check("r0_fifth_issue", 32'(r0_din_ready), 32'd1);
            step();
            if (k == 1) r0_din_valid = 0;
        end
        drain();

        // Tag FIFO full blocks reads, writes still proceed
        clear_inputs();
        sram_ready = 1; r0_din_valid = 1; r1_din_valid = 1; n_issued = 0;
        for (int k = 0; k < 10; k++) begin
            r0_din = 18'h10 + 18'(k); r1_din = 18'h20 + 18'(k);
            #1;
            n_issued += int'(r0_din_ready) + int'(r1_din_ready);
            step();
        end
        check("inflight_cap", 32'(n_issued), 32'd8);
        w1_din_valid = 1; w1_din = {4'hF, 18'h3FFFF, 32'h5A5A_5A5A};
        #1;
        check("full_write_valid", 32'(sram_addr_valid), 32'd1);
        check("full_write_addr", 32'(sram_addr), 32'h3FFFF);
        check("full_readies", 32'({r1_din_ready, r0_din_ready, w1_din_ready}), 32'b001);
        step();
        drain();

        // Interleaved returns steered by tag
        clear_inputs();
        sram_ready = 1; r0_dout_ready = 1; r1_dout_ready = 1;
        r0_din_valid = 1; r0_din = 18'h40;
        #1; check("il_issue_r0a", 32'(r0_din_ready), 32'd1); step();
        r0_din_valid = 0; r1_din_valid = 1; r1_din = 18'h41;
        #1; check("il_issue_r1", 32'(r1_din_ready), 32'd1); step();
        r1_din_valid = 0; r0_din_valid = 1; r0_din = 18'h42;
        #1; check("il_issue_r0b", 32'(r0_din_ready), 32'd1); step();
        r0_din_valid = 0;
        sram_data_out_valid = 1; sram_data_out = 32'hA0;
        step();
        sram_data_out = 32'hB1;
        #1;
        check("il_r0_first", {r0_dout_valid, r1_dout_valid} == 2'b10 ? r0_dout : 32'hFFFF_FFFF, 32'hA0);
        step();
        sram_data_out = 32'hA2;
        #1;
        check("il_r1", {r0_dout_valid, r1_dout_valid} == 2'b01 ? r1_dout : 32'hFFFF_FFFF, 32'hB1);
        step();
        sram_data_out_valid = 0;
        #1;
        check("il_r0_second", {r0_dout_valid, r1_dout_valid} == 2'b10 ? r0_dout : 32'hFFFF_FFFF, 32'hA2);
        step();

        // Orphan return after reset is sticky until the next reset
        clear_inputs();
        do_reset();
        sram_data_out_valid = 1; sram_data_out = 32'h1234;
        step();
        sram_data_out_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1; check("orphan_sticky", 32'(err_orphan), 32'd1);
            step();
        end
        reset = 1; step(); reset = 0;
        #1; check("orphan_cleared", 32'(err_orphan), 32'd0);
        step();

        // Reset mid-operation drops in-flight reads
        sram_ready = 1; r0_din_valid = 1; r0_din = 18'h55;
        step(); step();
        r0_din_valid = 0; sram_ready = 0;
        do_reset();
        sram_data_out_valid = 1; sram_data_out = 32'h77;
        step();
        sram_data_out_valid = 0;
        #1;
        check("orphan_midreset", 32'(err_orphan), 32'd1);
        check("midreset_no_data", 32'(r0_dout_valid), 32'd0);
        step();
        do_reset();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            w0_din_valid  = 1'($urandom_range(0, 1));
            w0_din        = {($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                             18'($urandom), 32'($urandom)};
            w1_din_valid  = 1'($urandom_range(0, 1));
            w1_din        = {($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                             18'($urandom), 32'($urandom)};
            r0_din_valid  = 1'($urandom_range(0, 1));
            r0_din        = 18'($urandom);
            r1_din_valid  = 1'($urandom_range(0, 1));
            r1_din        = 18'($urandom);
            r0_dout_ready = ($urandom_range(0, 3) != 0);
            r1_dout_ready = ($urandom_range(0, 3) != 0);
            sram_ready    = ($urandom_range(0, 3) != 0);
            sram_data_out_valid = (m_tags.size() > 0) && ($urandom_range(0, 1) == 1);
            sram_data_out = $urandom;
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_port_scheduler.md
SRAM_PORT_SCHEDULER -- requirements
Module: sram_port_scheduler

Interface
REQ-001 SHALL have parameter RD_FIFO_DEPTH, default 4, per-reader return-buffer depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter TAG_DEPTH, default 8, maximum in-flight SRAM reads (power of 2).
REQ-003 SHALL have port clock, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports wN_din_valid, input, 1, for N=0,1: writer N request valid.
REQ-006 SHALL have ports wN_din, input, 54, for N=0,1: {mask[53:50], addr[49:32], data[31:0]}.
REQ-007 SHALL have ports wN_din_ready, output, 1, for N=0,1: writer N accept.
REQ-008 SHALL have ports rN_din_valid, input, 1, for N=0,1: reader N address valid.
REQ-009 SHALL have ports rN_din, input, 18, for N=0,1: reader N SRAM word address.
REQ-010 SHALL have ports rN_din_ready, output, 1, for N=0,1: reader N address accept.
REQ-011 SHALL have ports rN_dout_valid, output, 1, and rN_dout, output, 32, for N=0,1: read data toward reader N.
REQ-012 SHALL have ports rN_dout_ready, input, 1, for N=0,1: reader N data accept.
REQ-013 SHALL have ports sram_addr_valid, output, 1, and sram_ready, input, 1: command handshake to the SRAM controller.
REQ-014 SHALL have ports sram_addr, output, 18; sram_data_in, output, 32; sram_write_mask, output, 4 (4'b0000 = read).
REQ-015 SHALL have ports sram_data_out, input, 32, and sram_data_out_valid, input, 1: in-order read returns with no backpressure.
REQ-016 SHALL have port err_orphan, output, 1: sticky flag for a return with no outstanding read.

Function
REQ-017 SHALL transfer every handshake on a rising edge where valid and ready are both high.
REQ-018 SHALL accept a writer request whose mask is 4'b0000 immediately (wN_din_ready=1), drop it, and never present it to arbitration.
REQ-019 SHALL treat writer N as eligible when wN_din_valid=1 and mask≠0.
REQ-020 SHALL treat reader N as eligible when rN_din_valid=1, credit_N<RD_FIFO_DEPTH, and the tag FIFO is not full.
REQ-021 SHALL define credit_N as reads in flight for reader N plus words held in reader N's return FIFO.
REQ-022 SHALL assign requester indices w0=0, w1=1, r0=2, r1=3.
REQ-023 SHALL grant round-robin: search from pointer p upward mod 4; reset value of p is 0.
REQ-024 SHALL set p to (grant+1) mod 4 after a command transfer and leave p unchanged otherwise.
REQ-025 SHALL drive sram_addr_valid high exactly when any requester is eligible, combinationally from inputs and registered state.
REQ-026 SHALL drive sram_addr, sram_data_in and sram_write_mask from the grantee; for a read grant, data_in=0 and mask=0; with no grant, all three are 0.
REQ-027 SHALL assert the grantee's din_ready as sram_ready; all other non-dropped readies SHALL be 0.
REQ-028 SHALL, on each read transfer, push the reader id into the tag FIFO and increment credit_N.
REQ-029 SHALL, on each sram_data_out_valid, pop the tag and write sram_data_out into that reader's return FIFO.
REQ-030 SHALL assert rN_dout_valid the cycle after the return (1-cycle latency) and sustain one word per cycle per reader.
REQ-031 SHALL drive rN_dout_valid as return FIFO non-empty and rN_dout as the FIFO head.
REQ-032 SHALL pop the head and decrement credit_N on each rN_dout_valid & rN_dout_ready.
REQ-033 SHALL leave credit_N unchanged when a read issue and a data pop for the same reader occur in the same cycle.
REQ-034 SHALL never overflow a return FIFO; overflow is prevented by credit.
REQ-035 SHALL deliver each reader's data in that reader's issue order.
REQ-036 SHALL, when the tag FIFO is full, block reads while writes continue.
REQ-037 SHALL, when sram_data_out_valid=1 with the tag FIFO empty, discard the data and set err_orphan until reset.

Reset
REQ-038 SHALL, on reset, clear p, all credits, the tag FIFO, both return FIFOs and err_orphan.
REQ-039 SHALL hold all outputs at 0 during reset and in the first cycle after it, absent inputs.
REQ-040 SHALL, on reset mid-operation, drop in-flight reads; returns arriving after reset SHALL set err_orphan (the SRAM controller shares reset).

Structure
REQ-041 SHALL place these in package sram_sched_pkg: requester index constants, field widths (ADDR_W=18, DATA_W=32, MASK_W=4, W_DIN_W=54) and the mask field offsets.
REQ-042 SHALL implement the tag FIFO and both return FIFOs as instances of one sub-module, sync_fifo (parameterised width/depth, full/empty flags, simultaneous push/pop).

Verification
REQ-043 SHALL cover: all four requesters held valid, sram_ready=1 -> grants w0,w1,r0,r1,w0... one per cycle.
REQ-044 SHALL cover: w0 mask=4'b0000 addr=5 -> w0_din_ready=1 same cycle, sram_addr_valid stays 0.
REQ-045 SHALL cover: r0 issues 5 reads with r0_dout_ready=0 -> exactly 4 issued, 5th issued only after one pop, data in issue order.
REQ-046 SHALL cover: 8 reads in flight, no return -> reads blocked, w1 write addr=0x3FFFF still issued.
REQ-047 SHALL cover: interleaved r0/r1 reads with returns 0xA0,0xB1,0xA2 -> r0 gets 0xA0,0xA2 and r1 gets 0xB1, each 1 cycle after its return.
REQ-048 SHALL cover: sram_data_out_valid pulse after reset with no reads -> err_orphan=1 until the next reset.
